// File: rtl/bcd_count_src.sv
// rtl/bcd_count_src.sv - multi-digit BCD up/down counter with parallel load (optional BCD_CNT_SAT_EN saturating mode)
module bcd_count_src #(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              ld,
    input  logic [4*NDIG-1:0] ld_val,
    output logic [4*NDIG-1:0] digits,
    output logic              vld,
    output logic              tc,
    output logic              err
);

    logic [4*NDIG-1:0] digits_d, digits_q;
    logic              vld_d, vld_q;
    logic              tc_d, tc_q;
    logic              err_d, err_q;

    logic [4*NDIG-1:0] step_val;
    logic [3:0]        nib;
    logic              ld_ok;
    logic              carry;

    // carry means every lower digit sits at its edge value (9 up, 0 down);
    // once it survives all digits the counter is at its terminal value.
    always_comb begin
        ld_ok    = 1'b1;
        carry    = 1'b1;
        step_val = digits_q;
        nib      = 4'd0;
        for (int k = 0; k < NDIG; k++) begin
            if (ld_val[4*k +: 4] > 4'd9) begin
                ld_ok = 1'b0;
            end
            nib = digits_q[4*k +: 4];
            if (carry) begin
                if (up) begin
                    step_val[4*k +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
                end else begin
                    step_val[4*k +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
                end
            end
            carry = carry & (nib == (up ? 4'd9 : 4'd0));
        end
    end

    always_comb begin
        digits_d = digits_q;
        vld_d    = 1'b0;
        tc_d     = 1'b0;
        err_d    = 1'b0;
        if (ld) begin
            if (ld_ok) begin
                digits_d = ld_val;
                vld_d    = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
`ifdef BCD_CNT_SAT_EN
            if (carry) begin
                tc_d = 1'b1;
            end else begin
                digits_d = step_val;
                vld_d    = 1'b1;
            end
`else
            digits_d = step_val;
            vld_d    = 1'b1;
            tc_d     = carry;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
            vld_q    <= 1'b0;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            vld_q    <= vld_d;
            tc_q     <= tc_d;
            err_q    <= err_d;
        end
    end

    assign digits = digits_q;
    assign vld    = vld_q;
    assign tc     = tc_q;
    assign err    = err_q;

endmodule
